// File: rtl/posit_encoder.sv
// posit_encoder: two-stage pipelined posit packer.
// Stage 1 builds the regime/exponent/fraction bit string and extracts guard
// and sticky; stage 2 rounds to nearest-even, clamps to maxpos/minpos and
// applies sign and special values. A shared enable stalls both stages.
module posit_encoder #(
  parameter int N  = 8,
  parameter int ES = 4,
  parameter int FW = 8,
  localparam int SW = ES + $clog2(N) + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic          in_zero,
  input  logic          in_nar,
  input  logic [SW-1:0] in_scale,
  input  logic [FW-1:0] in_frac,
  input  logic          in_sticky,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit
);

  // Seed string is "10"/"01" || e || frac, padded with N zeros so that the
  // largest regime shift never pushes significant bits off the bottom.
  localparam int LW  = 2 + ES + FW + N;
  localparam int SAT = (N - 2) << ES;
  localparam logic signed [SW-1:0] SAT_HI = SW'(SAT);
  localparam logic signed [SW-1:0] SAT_LO = SW'(-SAT);

  logic               w_en;
  logic signed [SW-1:0] w_scale;
  logic signed [SW-1:0] w_k;
  logic               w_k_neg;
  logic [SW-1:0]      w_shamt;
  logic [LW-1:0]      w_seed;
  logic [LW-1:0]      w_str;
  logic [N-2:0]       w_body1;
  logic               w_guard1;
  logic               w_sticky1;

  logic               r_v1;
  logic               r_v2;
  logic [N-2:0]       r_body;
  logic               r_guard;
  logic               r_sticky;
  logic               r_sign;
  logic               r_zero;
  logic               r_nar;
  logic [N-1:0]       r_out;

  logic               w_round;
  logic [N-1:0]       w_sum;
  logic [N-1:0]       w_mag;
  logic [N-1:0]       w_packed;

  assign w_en      = !r_v2 || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_v2;
  assign out_posit = r_out;

  assign w_scale = $signed(in_scale);
  assign w_k     = w_scale >>> ES;
  assign w_k_neg = w_k[SW-1];
  // k>=0 shifts "10" right by k filling ones; k<0 shifts "01" by -k-1 (= ~k) filling zeros.
  assign w_shamt = w_k_neg ? ~w_k : w_k;
  assign w_seed  = {(w_k_neg ? 2'b01 : 2'b10), in_scale[ES-1:0], in_frac, {N{1'b0}}};
  assign w_str   = w_k_neg ? (w_seed >> w_shamt) : ~((~w_seed) >> w_shamt);

  // Stage-1 body, guard and sticky, with scale saturation overriding the string.
  always_comb begin
    w_body1   = w_str[LW-1 -: N-1];
    w_guard1  = w_str[LW-N];
    w_sticky1 = (|w_str[LW-N-1:0]) | in_sticky;
    if (w_scale > SAT_HI) begin
      w_body1   = '1;
      w_guard1  = 1'b0;
      w_sticky1 = 1'b0;
    end else if (w_scale < SAT_LO) begin
      w_body1   = (N-1)'(1);
      w_guard1  = 1'b0;
      w_sticky1 = 1'b0;
    end
  end

  // Stage-2 round-to-nearest-even, clamp and two's-complement pack.
  always_comb begin
    w_round = r_guard & (r_sticky | r_body[0]);
    w_sum   = {1'b0, r_body} + {{(N-1){1'b0}}, w_round};
    w_mag   = w_sum;
    if (w_sum[N-1]) begin
      w_mag = {1'b0, {(N-1){1'b1}}};
    end else if (w_sum == '0) begin
      w_mag = N'(1);
    end
    w_packed = r_sign ? (~w_mag + N'(1)) : w_mag;
    if (r_nar) begin
      w_packed = {1'b1, {(N-1){1'b0}}};
    end else if (r_zero) begin
      w_packed = '0;
    end
  end

  // Stage-1 register: capture a newly accepted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_body   <= '0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
      r_sign   <= 1'b0;
      r_zero   <= 1'b0;
      r_nar    <= 1'b0;
    end else if (w_en) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_body   <= w_body1;
        r_guard  <= w_guard1;
        r_sticky <= w_sticky1;
        r_sign   <= in_sign;
        r_zero   <= in_zero;
        r_nar    <= in_nar;
      end
    end
  end

  // Stage-2 register: output word; holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2  <= 1'b0;
      r_out <= '0;
    end else if (w_en) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_out <= w_packed;
      end
    end
  end

endmodule

// File: doc/posit_encoder.md
Name: posit_encoder

Overview:
- Pipelined posit encoder. Packs an unpacked value into an N-bit posit: sign, zero/NaR flags, signed total scale, MSB-aligned fraction and sticky bit.
- It is the inverse of the field decoder at the front of the Posit_Multiplier datapath.
- It is the shared back-end for the multiplier, adder and divider datapaths.
- Valid/ready on both sides. Two register stages. Rounds to nearest, ties to even, with posit saturation.

Parameters:
- N, 8, posit width in bits.
- ES, 4, exponent field width.
- FW, 8, fraction input width (hidden bit excluded).
- SW, ES+$clog2(N)+2 (localparam), signed scale width; 9 at defaults.

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  encoder accepts a word this cycle.
- in_sign  input  1  1 = negative.
- in_zero  input  1  value is exactly zero.
- in_nar  input  1  value is NaR.
- in_scale  input  SW  signed total exponent: k*2^ES + e.
- in_frac  input  FW  fraction bits after the hidden 1, MSB-aligned.
- in_sticky  input  1  OR of fraction bits already discarded upstream.
- out_valid  output  1  out_posit is valid.
- out_ready  input  1  downstream accepts out_posit.
- out_posit  output  N  encoded posit, two's complement for negative values.

Behaviour:
- Reset (asynchronous, active-high): stage-1 and stage-2 valid bits clear; out_valid=0; out_posit=0; in_ready=1 after release. Reset mid-operation discards in-flight words with no output.
- Advance enable: en = !out_valid || out_ready. in_ready = en. When en=1, both stages shift together.
  - A word is accepted when in_valid && in_ready.
  - When en=0, all registers hold and out_posit is stable.
- Latency: 2 cycles from accept to out_valid when out_ready is held high. Throughput 1 word/cycle.
- Stage 1 (regime build):
  - k = in_scale >>> ES (floor); e = in_scale[ES-1:0].
  - Saturate: if scale > (N-2)*2^ES, force maxpos. If scale < -(N-2)*2^ES, force minpos.
  - Regime for k>=0: k+1 ones then a zero. Regime for k<0: -k zeros then a one.
  - Form the string regime||e||in_frac, left-justified into N-1 body bits.
  - Capture the guard bit (first bit below the body LSB) and the sticky bit (OR of all lower bits and in_sticky).
  - Register the body, guard, sticky, sign and the special flags.
- Stage 2 (round and pack):
  - round_up = guard && (sticky || body_lsb).
  - body = body + round_up, clamped to maxpos if the increment carries into the sign position.
  - A nonzero value never rounds to 0 and never reaches NaR; a result of 0 is forced to minpos.
  - Regime or exponent bits that fall below the LSB are rounded like fraction bits.
  - out_posit = sign ? -{0,body} : {0,body}.
- Specials:
  - in_nar has priority: out = 1 followed by N-1 zeros (0x80).
  - Otherwise in_zero gives out = 0. in_sign is ignored for both specials.
- Constants: maxpos = 0 followed by N-1 ones (0x7F); minpos = 0…01 (0x01).
- Simultaneous accept and output: when out_valid && out_ready && in_valid, the new word enters stage 1 and the stage-1 word moves to stage 2 in the same edge, so there are no bubbles.

Test Plan:
- Unit value: scale=0, frac=0x00, sign=0 → 0x40 after 2 cycles. Same with sign=1 → 0xC0.
- Regime step: scale=16, frac=0 → 0x60. scale=-16, frac=0 → 0x20. scale=96 → 0x7F.
- Rounding ties:
  - scale=0, frac=0xC0, sticky=0 (1.75) → 0x42 (tie, odd LSB rounds up).
  - frac=0x40 (1.25) → 0x40 (tie, even LSB stays).
  - frac=0x40 with sticky=1 → 0x41.
- Saturation and specials:
  - scale=200 → 0x7F; scale=-200 → 0x01; scale=-200 with sign=1 → 0xFF.
  - in_zero=1 → 0x00; in_nar=1 with in_zero=1 → 0x80.
- Backpressure:
  - Stream 4 words, then hold out_ready=0 for 3 cycles. out_posit stays stable, in_ready=0, no word is lost or duplicated, and output order matches input order.
  - Back-to-back operation at full rate gives 1 result/cycle.
- Reset mid-stream: assert rst asynchronously (between edges) with both stages full → out_valid and out_posit go to 0 immediately. After release the first new word appears 2 cycles after accept.
